// File: rtl/maxpool_writer_3ch_pkg.sv
// Shared constants, FSM state type and the signed max helper for the 3-channel max-pool writer.
package maxpool_writer_3ch_pkg;

   localparam int N_C        = 26;
   localparam int N_R        = 26;
   localparam int DATA_W     = 8;
   localparam int ADDR_W     = 10;
   localparam int PLANE_SIZE = (N_C / 2) * (N_R / 2);
   localparam int CNT_W      = 5;
   localparam int LB_W       = $clog2(N_C / 2);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2,
      DONE = 2'd3
   } state_e;

   // Two's-complement maximum of two samples.
   function automatic logic signed [DATA_W-1:0] smax(input logic signed [DATA_W-1:0] a,
                                                      input logic signed [DATA_W-1:0] b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/maxpool_lane.sv
// One channel of the 2x2 pooling datapath: pair register, half-width line buffer and signed compares.
// The window result is combinational; the top captures it on the odd-row/odd-col beat.
module maxpool_lane
   import maxpool_writer_3ch_pkg::*;
(
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     accept_i,
   input  logic                     col_odd_i,
   input  logic                     row_odd_i,
   input  logic [LB_W-1:0]          lb_idx_i,
   input  logic signed [DATA_W-1:0] sample_i,
   output logic signed [DATA_W-1:0] result_o
);

   logic signed [DATA_W-1:0] p_q;
   logic signed [DATA_W-1:0] lb_q [N_C/2];
   logic signed [DATA_W-1:0] pair_max;

   assign pair_max = smax(p_q, sample_i);
   assign result_o = smax(lb_q[lb_idx_i], pair_max);

   // Hold even-column samples; park even-row pair maxima in the line buffer.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         p_q <= '0;
         for (int i = 0; i < N_C/2; i++) lb_q[i] <= '0;
      end else if (accept_i) begin
         if (!col_odd_i) p_q <= sample_i;
         else if (!row_odd_i) lb_q[lb_idx_i] <= pair_max;
      end
   end

endmodule

// File: rtl/maxpool_writer_3ch.sv
// Streaming 2x2/stride-2 max-pool for three channels, producing pooled-memory write beats.
// Handshake: a pixel is accepted on any cycle where the FSM is in RUN and in_valid=1; there is
// no backpressure, so the producer simply holds in_valid low to stall.
module maxpool_writer_3ch
   import maxpool_writer_3ch_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] data_in1,
   input  logic signed [DATA_W-1:0] data_in2,
   input  logic signed [DATA_W-1:0] data_in3,
   output logic                     wen,
   output logic [ADDR_W-1:0]        wadd1,
   output logic [ADDR_W-1:0]        wadd2,
   output logic [ADDR_W-1:0]        wadd3,
   output logic signed [DATA_W-1:0] data_out1,
   output logic signed [DATA_W-1:0] data_out2,
   output logic signed [DATA_W-1:0] data_out3,
   output logic                     busy,
   output logic                     done
);

   localparam logic [CNT_W-1:0]  COL_LAST = CNT_W'(N_C - 1);
   localparam logic [CNT_W-1:0]  ROW_LAST = CNT_W'(N_R - 1);
   localparam logic [ADDR_W-1:0] PLANE_1  = ADDR_W'(PLANE_SIZE);
   localparam logic [ADDR_W-1:0] PLANE_2  = ADDR_W'(2 * PLANE_SIZE);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    col_q, col_d, row_q, row_d;
   logic [ADDR_W-1:0]   wcnt_q, wcnt_d;
   logic                wen_q;
   logic [ADDR_W-1:0]   wadd1_q, wadd2_q, wadd3_q;
   logic signed [DATA_W-1:0] dout1_q, dout2_q, dout3_q;
   logic signed [DATA_W-1:0] res1, res2, res3;
   logic                accept, last_px, wr_fire;

   assign accept  = (state_q == RUN) && in_valid;
   assign last_px = (row_q == ROW_LAST) && (col_q == COL_LAST);
   assign wr_fire = accept && row_q[0] && col_q[0];

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // FSM next state: start only matters in IDLE, so starts in RUN or DONE are dropped.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (accept && last_px) state_d = FIN;
         FIN:     state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Raster counters and running write address; all cleared when a frame starts.
   always_comb begin
      col_d  = col_q;
      row_d  = row_q;
      wcnt_d = wcnt_q;
      if (state_q == IDLE && start) begin
         col_d  = '0;
         row_d  = '0;
         wcnt_d = '0;
      end else if (accept) begin
         if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
         if (wr_fire) wcnt_d = wcnt_q + 1'b1;
      end
   end

   // Counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         col_q  <= '0;
         row_q  <= '0;
         wcnt_q <= '0;
      end else begin
         col_q  <= col_d;
         row_q  <= row_d;
         wcnt_q <= wcnt_d;
      end
   end

   maxpool_lane u_lane1 (
      .clk_i(clk), .rst_i(rst), .accept_i(accept), .col_odd_i(col_q[0]), .row_odd_i(row_q[0]),
      .lb_idx_i(col_q[CNT_W-1:1]), .sample_i(data_in1), .result_o(res1)
   );
   maxpool_lane u_lane2 (
      .clk_i(clk), .rst_i(rst), .accept_i(accept), .col_odd_i(col_q[0]), .row_odd_i(row_q[0]),
      .lb_idx_i(col_q[CNT_W-1:1]), .sample_i(data_in2), .result_o(res2)
   );
   maxpool_lane u_lane3 (
      .clk_i(clk), .rst_i(rst), .accept_i(accept), .col_odd_i(col_q[0]), .row_odd_i(row_q[0]),
      .lb_idx_i(col_q[CNT_W-1:1]), .sample_i(data_in3), .result_o(res3)
   );

   // Write port: one-cycle strobe after each completed window; address/data hold between writes.
   always_ff @(posedge clk) begin
      if (rst) begin
         wen_q   <= 1'b0;
         wadd1_q <= '0;
         wadd2_q <= '0;
         wadd3_q <= '0;
         dout1_q <= '0;
         dout2_q <= '0;
         dout3_q <= '0;
      end else begin
         wen_q <= wr_fire;
         if (wr_fire) begin
            wadd1_q <= wcnt_q;
            wadd2_q <= wcnt_q + PLANE_1;
            wadd3_q <= wcnt_q + PLANE_2;
            dout1_q <= res1;
            dout2_q <= res2;
            dout3_q <= res3;
         end
      end
   end

   assign wen       = wen_q;
   assign wadd1     = wadd1_q;
   assign wadd2     = wadd2_q;
   assign wadd3     = wadd3_q;
   assign data_out1 = dout1_q;
   assign data_out2 = dout2_q;
   assign data_out3 = dout3_q;
   assign busy      = (state_q == RUN);
   assign done      = (state_q == DONE);

endmodule

// File: tb/tb_maxpool_writer_3ch.sv
// Bench for maxpool_writer_3ch: image-level pooling model, per-cycle write checker, directed frames.
module tb_maxpool_writer_3ch;

   localparam int NC = 26;
   localparam int NR = 26;
   localparam int PC = NC / 2;
   localparam int PR = NR / 2;

   logic clk, rst, start, in_valid;
   logic [7:0] data_in1, data_in2, data_in3;
   logic wen, busy, done;
   logic [9:0] wadd1, wadd2, wadd3;
   logic [7:0] data_out1, data_out2, data_out3;

   maxpool_writer_3ch dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
      .data_in1(data_in1), .data_in2(data_in2), .data_in3(data_in3),
      .wen(wen), .wadd1(wadd1), .wadd2(wadd2), .wadd3(wadd3),
      .data_out1(data_out1), .data_out2(data_out2), .data_out3(data_out3),
      .busy(busy), .done(done)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int n_writes = 0;

   logic signed [7:0] pix [3][NR][NC];
   logic [33:0] exp_q[$];
   logic [33:0] e;
   logic        prev_last;
   logic [7:0]  first_d1, first_d2, first_d3;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   // image fill: 0 = ramp, 1 = random, 2 = random with a signed corner window in channel 2
   task automatic fill_image(input int mode);
      for (int ch = 0; ch < 3; ch++)
         for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
               if (mode == 0) pix[ch][r][c] = 8'((r * NC + c) % 128);
               else pix[ch][r][c] = 8'($urandom_range(255));
      if (mode == 2) begin
         pix[1][0][0] = -8'sd128;
         pix[1][0][1] = -8'sd1;
         pix[1][1][0] = -8'sd5;
         pix[1][1][1] = -8'sd128;
      end
   endtask

   // model: pooled write list in ascending address order
   task automatic build_expected();
      logic [7:0] d [3];
      logic [9:0] a;
      int best, v;
      exp_q.delete();
      for (int pr = 0; pr < PR; pr++)
         for (int pc = 0; pc < PC; pc++) begin
            for (int ch = 0; ch < 3; ch++) begin
               best = -1000;
               for (int dr = 0; dr < 2; dr++)
                  for (int dc = 0; dc < 2; dc++) begin
                     v = int'(pix[ch][2*pr+dr][2*pc+dc]);
                     if (v > best) best = v;
                  end
               d[ch] = 8'(best);
            end
            a = 10'(pr * PC + pc);
            exp_q.push_back({a, d[0], d[1], d[2]});
         end
   endtask

   // scoreboard: every write beat is checked against the model, done must follow the last write
   always @(negedge clk) begin
      if (rst) begin
         prev_last = 1'b0;
      end else begin
         if (wen) begin
            n_writes++;
            if (exp_q.size() == 0) begin
               chk("wen_without_pending_write", wen, 1'b0);
            end else begin
               e = exp_q.pop_front();
               chk("wadd1", wadd1, e[33:24]);
               chk("wadd2", wadd2, 10'(e[33:24] + 10'd169));
               chk("wadd3", wadd3, 10'(e[33:24] + 10'd338));
               chk("data_out1", data_out1, e[23:16]);
               chk("data_out2", data_out2, e[15:8]);
               chk("data_out3", data_out3, e[7:0]);
            end
            if (wadd1 == 10'd0) begin
               first_d1 = data_out1;
               first_d2 = data_out2;
               first_d3 = data_out3;
            end
         end
         chk("done_one_cycle_after_last_write", done, prev_last);
         prev_last = wen && (wadd1 == 10'd167 + 10'd1);
      end
   end

   task automatic drive_pixel(input int r, input int c, input bit noise);
      in_valid = 1'b1;
      data_in1 = pix[0][r][c];
      data_in2 = pix[1][r][c];
      data_in3 = pix[2][r][c];
      start    = noise ? 1'($urandom_range(1)) : 1'b0;
      @(posedge clk); #1;
   endtask

   // driver: one frame from the already-built model image
   task automatic run_frame(input int gap_pct, input int idle_noise, input bit start_noise,
                            input bit start_in_done);
      bit found;
      for (int i = 0; i < idle_noise; i++) begin
         in_valid = 1'b1;
         data_in1 = 8'($urandom_range(255));
         data_in2 = 8'($urandom_range(255));
         data_in3 = 8'($urandom_range(255));
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("busy_in_run", busy, 1'b1);
      for (int r = 0; r < NR; r++)
         for (int c = 0; c < NC; c++) begin
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
               in_valid = 1'b0;
               data_in1 = 8'($urandom_range(255));
               data_in2 = 8'($urandom_range(255));
               data_in3 = 8'($urandom_range(255));
               start    = start_noise ? 1'($urandom_range(1)) : 1'b0;
               @(posedge clk); #1;
            end
            drive_pixel(r, c, start_noise);
         end
      in_valid = 1'b0;
      start = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (done) begin
            found = 1'b1;
            break;
         end
      end
      chk("done_seen", found, 1'b1);
      if (start_in_done) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("model_queue_drained", exp_q.size(), 0);
      if (start_in_done) begin
         @(negedge clk);
         chk("start_during_done_ignored", busy, 1'b0);
      end
   endtask

   initial begin
      int w0;
      rst = 1'b1; start = 1'b0; in_valid = 1'b0;
      data_in1 = '0; data_in2 = '0; data_in3 = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_wen", wen, 1'b0);
      chk("rst_wadd1", wadd1, 10'd0);
      chk("rst_wadd3", wadd3, 10'd0);
      chk("rst_data_out2", data_out2, 8'd0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);

      // ramp frame, continuous valid, with in_valid noise while idle
      fill_image(0);
      build_expected();
      chk("model_first_addr", exp_q[0][33:24], 10'd0);
      chk("model_first_data", exp_q[0][23:16], 8'd27);
      chk("model_last_addr", exp_q[168][33:24], 10'd168);
      chk("model_last_data", exp_q[168][7:0], 8'd35);
      run_frame(0, 3, 1'b0, 1'b0);
      chk("ramp_first_d1", first_d1, 8'd27);
      chk("ramp_first_d3", first_d3, 8'd27);

      // signed window in channel 2
      fill_image(2);
      build_expected();
      chk("model_signed_window", exp_q[0][15:8], 8'hFF);
      run_frame(0, 0, 1'b0, 1'b0);
      chk("signed_first_d2", first_d2, 8'hFF);

      // random data, ~50% gaps, start pulses during run
      fill_image(1);
      build_expected();
      run_frame(50, 2, 1'b1, 1'b0);

      // reset after 300 accepted pixels
      fill_image(1);
      build_expected();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 300; i++) drive_pixel(i / NC, i % NC, 1'b0);
      rst = 1'b1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
      @(negedge clk);
      chk("midrst_wen", wen, 1'b0);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_wadd1", wadd1, 10'd0);
      @(negedge clk);
      chk("midrst_wen_next", wen, 1'b0);

      // fresh frame after reset, start also pulsed in the done cycle
      fill_image(1);
      build_expected();
      run_frame(20, 0, 1'b0, 1'b1);

      // two back-to-back frames
      w0 = n_writes;
      fill_image(1);
      build_expected();
      run_frame(10, 0, 1'b0, 1'b0);
      fill_image(1);
      build_expected();
      run_frame(0, 0, 1'b0, 1'b0);
      chk("back_to_back_writes", n_writes - w0, 338);

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // global time bound
   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/maxpool_writer_3ch.md
Name: maxpool_writer_3ch

Overview:
- Streaming 2x2 / stride-2 max-pooling engine for the three parallel conv-filter channels.
- Consumes conv results in raster order, one pixel per channel per accepted beat.
- Produces the write side of the pooled-result memory: wen, wadd1/2/3, data_in1/2/3 (three channel planes of 13x13 = 507 entries).
- Sits between the conv engine output and the pooled-result memory in the maxpooling SoC.

Parameters:
- n_c, 26, input columns per channel (even)
- n_r, 26, input rows per channel (even)
- dataWidthRstlConv, 8, signed sample width
- addressWidthRstlConv, 10, write address width
- planeSize, 169, pooled entries per channel, = (n_c/2)*(n_r/2)

Ports:
- clk  in  1  single clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a frame when idle
- in_valid  in  1  data_in1..3 valid this cycle
- data_in1  in  8  signed conv result, channel 1
- data_in2  in  8  signed conv result, channel 2
- data_in3  in  8  signed conv result, channel 3
- wen  out  1  write strobe to pooled memory
- wadd1  out  10  pooled index, channel 1 (0..168)
- wadd2  out  10  wadd1 + planeSize (169..337)
- wadd3  out  10  wadd1 + 2*planeSize (338..506)
- data_out1  out  8  pooled max, channel 1
- data_out2  out  8  pooled max, channel 2
- data_out3  out  8  pooled max, channel 3
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse after the last write

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM returns to IDLE.
  - row/col counters and line buffer cleared.
- FSM states and transitions:
  - IDLE, on start=1: go to RUN; row=0, col=0.
  - RUN: each cycle with in_valid=1 is one accepted pixel (all three channels).
  - RUN, on the accepted pixel at row=n_r-1, col=n_c-1: go to FIN.
  - FIN: the last wen is asserted this cycle; go to DONE.
  - DONE: done=1 for one cycle; go to IDLE.
- Counters:
  - col increments per accepted pixel.
  - At n_c-1, col wraps to 0 and row increments.
  - No bubbles are inserted; in_valid gaps simply stall the counters.
- Per-channel datapath:
  - Even col: hold the sample in pair register p.
  - Odd col: m = max(p, sample).
  - Even row: store m in line buffer lb[col>>1]; lb has n_c/2 entries per channel.
  - Odd row: result = max(lb[col>>1], m).
- Write generation, on the odd-row/odd-col accepted pixel:
  - Next cycle (latency 1): wen=1.
  - wadd1 = (row>>1)*(n_c/2) + (col>>1); wadd2 = wadd1+169; wadd3 = wadd1+338.
  - data_outN = the channel-N result.
  - wen is 0 in all other cycles; address/data hold their last value.
- Arithmetic:
  - All comparisons are signed two's complement; -1 > -128.
  - No saturation or offset is applied; output width equals input width.
  - The wadd1 multiply may be replaced by a running counter incremented per write, reset per frame.
- Exactly planeSize (169) writes per frame, in ascending wadd1 order.
- Boundary conditions:
  - in_valid while IDLE/FIN/DONE: ignored.
  - start while RUN: ignored.
  - start in the same cycle as done: ignored; it is accepted in IDLE the next cycle.
  - rst mid-frame: wen drops to 0 the same edge, no further writes, FSM to IDLE; the partial frame is discarded.
  - in_valid=1 on every cycle: sustained, no stall.

Decomposition:
- Shared package:
  - Constants N_C, N_R, DATA_W, ADDR_W, PLANE_SIZE.
  - FSM state enum {IDLE, RUN, FIN, DONE}.
- Sub-module: maxpool_lane, instantiated 3x. It holds one channel's pair register, line buffer and signed max compares, with its control (phase bits, lb index) driven from the top-level counters.

Test Plan:
- Ramp input, value = (r*26+c) mod 128 on all channels, in_valid continuous -> 169 writes.
  - Write 0: wadd1=0, wadd2=169, wadd3=338, data=27.
  - Last write: wadd1=168, wadd2=337, wadd3=506; done one cycle later.
- Signed check, 2x2 window {-128,-1,-5,-128} in channel 2 -> data_out2 = -1 (8'hFF); channels 1/3 unaffected.
- Random in_valid gaps (≈50% duty), random data -> write sequence identical to the golden model; wen never asserted during a stall unless the write is pending from the prior accepted pixel.
- rst asserted after 300 accepted pixels -> wen=0 from next edge, busy=0; a new start yields a complete correct frame from wadd1=0.
- Two back-to-back frames (start issued the cycle after done) -> 338 writes total, second frame addresses restart at 0.
- start pulsed during RUN and in_valid pulsed during IDLE -> no effect on counters or writes.
